// File: rtl/enc_16x4_prio.sv
// 16-to-4 priority encoder (highest set bit wins) behind a one-entry valid/ready output register.
// Define ENC_ERR_CNT_EN to build the saturating faulty-word counter; otherwise ERR_CNT reads zero.
module enc_16x4_prio (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [15:0] D,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       W,
    output logic       NONE,
    output logic       MULTI,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    input  logic       CLR_CNT,
    output logic [7:0] ERR_CNT
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        none_q, none_d;
    logic        multi_q, multi_d;
    logic [4:0]  pop;
    logic        in_xfer;
    logic        out_xfer;

    // Later set bits overwrite earlier ones, so the highest index wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        idx_d = 4'd0;
        pop   = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (D[i]) begin
                idx_d = 4'(i);
                pop   = pop + 5'd1;
            end
        end
        none_d  = (D == 16'h0000);
        multi_d = (pop > 5'd1);
    end

    // Ready is gated by reset so nothing is accepted while the block is held.
    assign IN_READY = RST_N && ((state_q == EMPTY) || OUT_READY);
    assign in_xfer  = IN_VALID && IN_READY;
    assign out_xfer = (state_q == FULL) && OUT_READY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = FULL;
            FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            idx_q   <= 4'd0;
            none_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                idx_q   <= idx_d;
                none_q  <= none_d;
                multi_q <= multi_d;
            end
        end
    end

    assign X         = idx_q[3];
    assign Y         = idx_q[2];
    assign Z         = idx_q[1];
    assign W         = idx_q[0];
    assign NONE      = none_q;
    assign MULTI     = multi_q;
    assign OUT_VALID = (state_q == FULL);

`ifdef ENC_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Clear beats a same-cycle increment; the count sticks at 8'hFF.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR_CNT) begin
            cnt_d = 8'h00;
        end else if (in_xfer && (none_d || multi_d) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ERR_CNT = cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = CLR_CNT;
    assign ERR_CNT        = 8'h00;
`endif

endmodule

// File: tb/tb_enc_16x4_prio.sv
// Self-checking bench for enc_16x4_prio: directed steps plus random traffic against a behavioural model.
// Expected ERR_CNT follows ENC_ERR_CNT_EN, matching the build of the design.
module tb_enc_16x4_prio;

`ifdef ENC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] D;
    logic        IN_VALID;
    logic        IN_READY;
    logic        X, Y, Z, W;
    logic        NONE;
    logic        MULTI;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        CLR_CNT;
    logic [7:0]  ERR_CNT;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit       m_valid;
    int       m_idx;
    bit       m_none;
    bit       m_multi;
    int       m_cnt;

    enc_16x4_prio dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .D         (D),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .W         (W),
        .NONE      (NONE),
        .MULTI     (MULTI),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CLR_CNT   (CLR_CNT),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic int ref_idx(input logic [15:0] d);
        int v;
        v = int'(d);
        return (v == 0) ? 0 : $clog2(v + 1) - 1;
    endfunction

    function automatic bit is_faulty(input logic [15:0] d);
        return $countones(d) != 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(OUT_VALID), 32'(m_valid));
        check("xyzw", 32'({X, Y, Z, W}), 32'(m_idx));
        check("none", 32'(NONE), 32'(m_none));
        check("multi", 32'(MULTI), 32'(m_multi));
        check("err_cnt", 32'(ERR_CNT), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_none  = 1'b0;
        m_multi = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: check ready against the model, advance model over the edge, then check outputs.
    task automatic cycle();
        bit exp_ready, in_x, out_x;
        #1;
        exp_ready = !m_valid || OUT_READY;
        check("in_ready", 32'(IN_READY), 32'(exp_ready));
        in_x  = IN_VALID && exp_ready;
        out_x = m_valid && OUT_READY;
        @(posedge CLK);
        if (in_x) begin
            m_idx   = ref_idx(D);
            m_none  = (D == 16'h0000);
            m_multi = ($countones(D) > 1);
        end
        if (CNT_EN) begin
            if (CLR_CNT) m_cnt = 0;
            else if (in_x && is_faulty(D) && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        if (in_x) m_valid = 1'b1;
        else if (out_x) m_valid = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        logic [15:0] d;

        RST_N     = 1'b0;
        D         = 16'h0000;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        CLR_CNT   = 1'b0;
        model_reset();

        // Reset state, including ready held low
        repeat (3) @(posedge CLK);
        #1;
        check_outputs();
        check("in_ready_rst", 32'(IN_READY), 32'd0);
        RST_N = 1'b1;

        // First transfer: latency one
        D = 16'h0001; IN_VALID = 1'b1; OUT_READY = 1'b1;
        cycle();
        check("first_xyzw", 32'({X, Y, Z, W}), 32'd0);
        check("first_valid", 32'(OUT_VALID), 32'd1);

        // Back-to-back one-hot sweep
        for (int k = 0; k < 16; k++) begin
            D = 16'(1 << k);
            cycle();
            check("sweep_xyzw", 32'({X, Y, Z, W}), 32'(k));
            check("sweep_valid", 32'(OUT_VALID), 32'd1);
        end

        // Multi-bit then all-zero words
        D = 16'h8001;
        cycle();
        check("multi_xyzw", 32'({X, Y, Z, W}), 32'hF);
        check("multi_flag", 32'(MULTI), 32'd1);
        D = 16'h0000;
        cycle();
        check("zero_xyzw", 32'({X, Y, Z, W}), 32'h0);
        check("zero_none", 32'(NONE), 32'd1);
        check("zero_multi", 32'(MULTI), 32'd0);
        check("cnt_two", 32'(ERR_CNT), CNT_EN ? 32'd2 : 32'd0);

        // Backpressure: result holds while the consumer stalls
        D = 16'h0010;
        cycle();
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D = 16'($urandom);
            cycle();
            check("stall_xyzw", 32'({X, Y, Z, W}), 32'h4);
            check("stall_ready", 32'(IN_READY), 32'd0);
        end
        D = 16'h0400; OUT_READY = 1'b1;
        cycle();
        check("release_xyzw", 32'({X, Y, Z, W}), 32'hA);

        // Saturation then clear: start from a zero count
        IN_VALID = 1'b0; CLR_CNT = 1'b1;
        cycle();
        CLR_CNT = 1'b0; IN_VALID = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            d = (i % 10 == 0) ? 16'h0000 : 16'($urandom);
            if ($countones(d) == 1) d = d | ((d == 16'h0001) ? 16'h0002 : 16'h0001);
            D = d;
            CLR_CNT = (i == 300);
            cycle();
            if (i == 255) check("cnt_reach", 32'(ERR_CNT), CNT_EN ? 32'd255 : 32'd0);
            if (i == 299) check("cnt_hold", 32'(ERR_CNT), CNT_EN ? 32'd255 : 32'd0);
            if (i == 300) check("cnt_clear", 32'(ERR_CNT), 32'd0);
        end
        CLR_CNT = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            CLR_CNT   = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       D = 16'h0000;
                1:       D = 16'(1 << $urandom_range(0, 15));
                default: D = 16'($urandom);
            endcase
            cycle();
        end
        CLR_CNT = 1'b0;

        // Asynchronous reset while holding a result
        D = 16'hF000; IN_VALID = 1'b1; OUT_READY = 1'b0;
        cycle();
        cycle();
        check("pre_rst_valid", 32'(OUT_VALID), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("in_ready_async", 32'(IN_READY), 32'd0);

        // First transfer after release
        #2;
        RST_N = 1'b1;
        D = 16'h0020; IN_VALID = 1'b1; OUT_READY = 1'b1;
        cycle();
        check("post_rst_xyzw", 32'({X, Y, Z, W}), 32'h5);
        check("post_rst_valid", 32'(OUT_VALID), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc_16x4_prio.md
ENC_16X4_PRIO -- requirements
Module: enc_16x4_prio

Interface
REQ-001 The block SHALL provide port CLK, input, 1 bit, single rising-edge clock for all state.
REQ-002 The block SHALL provide port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL provide port D, input, 16 bits, decoder-output word to be encoded.
REQ-004 The block SHALL provide port IN_VALID, input, 1 bit, D is valid this cycle.
REQ-005 The block SHALL provide port IN_READY, output, 1 bit, block accepts D this cycle.
REQ-006 The block SHALL provide ports X, Y, Z, W, outputs, 1 bit each, registered encoded index; X is the MSB and W the LSB.
REQ-007 The block SHALL provide port NONE, output, 1 bit, registered flag meaning the captured D was all-zero.
REQ-008 The block SHALL provide port MULTI, output, 1 bit, registered flag meaning the captured D had more than one bit set.
REQ-009 The block SHALL provide port OUT_VALID, output, 1 bit, result registers hold an undelivered result.
REQ-010 The block SHALL provide port OUT_READY, input, 1 bit, consumer takes the result this cycle.
REQ-011 The block SHALL provide port CLR_CNT, input, 1 bit, synchronous clear of ERR_CNT.
REQ-012 The block SHALL provide port ERR_CNT, output, 8 bits, count of faulty words accepted.

Function
REQ-013 The block SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, OUT_VALID=1).
REQ-014 An input transfer SHALL occur on any rising edge where IN_VALID=1 and IN_READY=1; an output transfer SHALL occur on any rising edge where OUT_VALID=1 and OUT_READY=1.
REQ-015 IN_READY SHALL be 1 in EMPTY and SHALL equal OUT_READY in FULL; this path is combinational.
REQ-016 In EMPTY, an input transfer SHALL load the result registers and move the FSM to FULL, so OUT_VALID rises one cycle after acceptance (latency 1).
REQ-017 In FULL, simultaneous input and output transfers SHALL replace the result with the new word and keep the FSM in FULL, giving full throughput with no bubble.
REQ-018 In FULL, an output transfer without an input transfer SHALL move the FSM to EMPTY.
REQ-019 In FULL with OUT_READY=0, X, Y, Z, W, NONE and MULTI SHALL hold stable.
REQ-020 {X,Y,Z,W} SHALL equal the index of the highest-numbered set bit of D (highest index wins).
REQ-021 For D=16'h0000, {X,Y,Z,W} SHALL be 4'b0000 and NONE SHALL be 1.
REQ-022 MULTI SHALL be 1 if and only if the population count of D is greater than 1; NONE and MULTI SHALL never both be 1.
REQ-023 The encode and flag logic SHALL be combinational on D and registered only at input transfer.
REQ-024 ERR_CNT SHALL increment by 1 on each input transfer where NONE or MULTI would be set.
REQ-025 ERR_CNT SHALL saturate at 8'hFF.
REQ-026 CLR_CNT=1 SHALL set ERR_CNT to 0 on the next edge; clear SHALL take priority over a simultaneous increment.

Reset
REQ-027 While RST_N=0, the block SHALL hold the FSM in EMPTY with OUT_VALID=0, X=Y=Z=W=0, NONE=0, MULTI=0 and ERR_CNT=0, independent of CLK.
REQ-028 While RST_N=0, IN_READY SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held result; the first input transfer SHALL occur on the first rising edge with RST_N=1 and IN_VALID=1.

Configuration
REQ-030 When macro ENC_ERR_CNT_EN is defined, the error counter SHALL be implemented as specified in REQ-024 to REQ-026.
REQ-031 When ENC_ERR_CNT_EN is undefined, ERR_CNT SHALL be tied to 8'h00, CLR_CNT SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-032 The bench SHALL apply reset, then D=16'h0001 with IN_VALID=1 and OUT_READY=1, and SHALL check that XYZW=0000, NONE=0, MULTI=0 and OUT_VALID=1 one cycle later.
REQ-033 The bench SHALL sweep D=1<<k for k=0..15 back-to-back with OUT_READY=1, and SHALL check that XYZW=k on consecutive cycles with no bubble.
REQ-034 The bench SHALL apply D=16'h8001 and then D=16'h0000, and SHALL check XYZW=1111 with MULTI=1, then XYZW=0000 with NONE=1, and ERR_CNT=2 (with the macro) or 0 (without it).
REQ-035 The bench SHALL apply D=16'h0010 with OUT_READY=0 for 5 cycles while D changes, and SHALL check that XYZW=0100 holds, IN_READY=0, and the result changes only after OUT_READY=1.
REQ-036 The bench SHALL apply 300 faulty words with CLR_CNT pulsed together with the 300th, and SHALL check that ERR_CNT reaches 255, holds at 255, and then reads 0.
REQ-037 The bench SHALL drive RST_N=0 asynchronously between clock edges while in FULL, and SHALL check that OUT_VALID=0 and all outputs are 0 immediately, before the next edge.
